// File: rtl/lstm_seq_ctrl.sv
// Timestep sequencer for an LSTM cell: registers x_t, waits the cell latency, feeds h/c back.
// Optional LSTM_STEP_CNT_EN adds a saturating per-sequence step counter output.
module lstm_seq_ctrl #(
  parameter int CELL_LAT = 4,
  parameter int W        = 8
) (
  input  logic           CLOCK_50,
  input  logic           reset_n,
  input  logic           x_valid,
  output logic           x_ready,
  input  logic [8*W-1:0] x_data,
  input  logic           x_last,
  output logic [8*W-1:0] cell_xt,
  output logic [8*W-1:0] cell_ht1,
  output logic [W-1:0]   cell_ct1,
  input  logic [W-1:0]   cell_ht,
  input  logic [W-1:0]   cell_ct,
  output logic           h_valid,
  input  logic           h_ready,
  output logic [W-1:0]   h_data,
  output logic           h_last
`ifdef LSTM_STEP_CNT_EN
  ,
  output logic [15:0]    step_cnt
`endif
);

  localparam logic [3:0] LAT = 4'(CELL_LAT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [8*W-1:0] xt_q, xt_d;
  logic [8*W-1:0] ht1_q, ht1_d;
  logic [W-1:0]   ct1_q, ct1_d;
  logic [W-1:0]   h_data_q, h_data_d;
  logic           h_last_q, h_last_d;
  logic           last_q, last_d;
  logic [15:0]    sc_q, sc_d;

  logic accept, capture, out_hs;

  assign accept  = (state_q == S_IDLE) && x_valid;
  assign capture = (state_q == S_WAIT) && (cnt_q == 4'd1);
  assign out_hs  = (state_q == S_OUT) && h_ready;

  // State register and all datapath registers; reset discards any in-flight step
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      xt_q     <= '0;
      ht1_q    <= '0;
      ct1_q    <= '0;
      h_data_q <= '0;
      h_last_q <= 1'b0;
      last_q   <= 1'b0;
      sc_q     <= 16'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      xt_q     <= xt_d;
      ht1_q    <= ht1_d;
      ct1_q    <= ct1_d;
      h_data_q <= h_data_d;
      h_last_q <= h_last_d;
      last_q   <= last_d;
      sc_q     <= sc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (x_valid)        state_d = S_WAIT;
      S_WAIT:  if (cnt_q == 4'd1)  state_d = S_OUT;
      S_OUT:   if (h_ready)        state_d = S_IDLE;
      default:                     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    xt_d     = xt_q;
    ht1_d    = ht1_q;
    ct1_d    = ct1_q;
    h_data_d = h_data_q;
    h_last_d = h_last_q;
    last_d   = last_q;
    sc_d     = sc_q;
    if (accept) begin
      xt_d   = x_data;
      last_d = x_last;
      cnt_d  = LAT;
    end
    if (state_q == S_WAIT) begin
      cnt_d = cnt_q - 4'd1;
    end
    // Cell outputs are stable by now; latch them and shift h into the history
    if (capture) begin
      h_data_d = cell_ht;
      ct1_d    = cell_ct;
      ht1_d    = {ht1_q[7*W-1:0], cell_ht};
      h_last_d = last_q;
      if (sc_q != 16'hFFFF) begin
        sc_d = sc_q + 16'd1;
      end
    end
    if (out_hs && last_q) begin
      ht1_d = '0;
      ct1_d = '0;
      sc_d  = 16'd0;
    end
  end

  always_comb begin
    x_ready  = (state_q == S_IDLE);
    h_valid  = (state_q == S_OUT);
    h_data   = h_data_q;
    h_last   = h_last_q;
    cell_xt  = xt_q;
    cell_ht1 = ht1_q;
    cell_ct1 = ct1_q;
  end

`ifdef LSTM_STEP_CNT_EN
  assign step_cnt = sc_q;
`else
  logic sc_unused;
  assign sc_unused = ^sc_q;
`endif

endmodule

// File: tb/tb_lstm_seq_ctrl.sv
// Directed bench for lstm_seq_ctrl with a latency-4 cell stub (ht = xt[7:0]+ht1[7:0], ct = ct1+1).
module tb_lstm_seq_ctrl;
  localparam int CELL_LAT = 4;
  localparam int W = 8;

  logic           CLOCK_50 = 1'b0;
  logic           reset_n;
  logic           x_valid;
  logic           x_ready;
  logic [8*W-1:0] x_data;
  logic           x_last;
  logic [8*W-1:0] cell_xt;
  logic [8*W-1:0] cell_ht1;
  logic [W-1:0]   cell_ct1;
  logic [W-1:0]   cell_ht;
  logic [W-1:0]   cell_ct;
  logic           h_valid;
  logic           h_ready;
  logic [W-1:0]   h_data;
  logic           h_last;
`ifdef LSTM_STEP_CNT_EN
  logic [15:0]    step_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_sc = 16'd0;

  always #5 CLOCK_50 = ~CLOCK_50;

  lstm_seq_ctrl #(.CELL_LAT(CELL_LAT), .W(W)) dut (
    .CLOCK_50(CLOCK_50),
    .reset_n (reset_n),
    .x_valid (x_valid),
    .x_ready (x_ready),
    .x_data  (x_data),
    .x_last  (x_last),
    .cell_xt (cell_xt),
    .cell_ht1(cell_ht1),
    .cell_ct1(cell_ct1),
    .cell_ht (cell_ht),
    .cell_ct (cell_ct),
    .h_valid (h_valid),
    .h_ready (h_ready),
    .h_data  (h_data),
    .h_last  (h_last)
`ifdef LSTM_STEP_CNT_EN
    ,
    .step_cnt(step_cnt)
`endif
  );

  // Cell stub: three register stages, so outputs settle just before edge E0+CELL_LAT
  logic [W-1:0] st_ht [3] = '{default: '0};
  logic [W-1:0] st_ct [3] = '{default: '0};
  always @(posedge CLOCK_50) begin
    st_ht[0] <= cell_xt[7:0] + cell_ht1[7:0];
    st_ht[1] <= st_ht[0];
    st_ht[2] <= st_ht[1];
    st_ct[0] <= cell_ct1 + 8'd1;
    st_ct[1] <= st_ct[0];
    st_ct[2] <= st_ct[1];
  end
  assign cell_ht = st_ht[2];
  assign cell_ct = st_ct[2];

  typedef struct {
    logic [63:0] xd;
    logic        xl;
    logic [7:0]  eh;
    logic [63:0] e_ht1;
    logic [7:0]  e_ct1;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic run_step(input vec_t v);
    int n;
    x_data  = v.xd;
    x_last  = v.xl;
    x_valid = 1'b1;
    h_ready = 1'b1;
    chk("x_ready_idle", 64'(x_ready), 64'd1);
    tick();
    x_valid = 1'b0;
    x_data  = 64'hA5A5_A5A5_A5A5_A5A5;
    chk("cell_xt", cell_xt, v.xd);
    chk("cell_ht1", cell_ht1, v.e_ht1);
    chk("cell_ct1", 64'(cell_ct1), 64'(v.e_ct1));
    chk("x_ready_wait", 64'(x_ready), 64'd0);
    n = 0;
    while (!h_valid && n < 40) begin
      tick();
      n++;
    end
    chk("latency", 64'(n), 64'(CELL_LAT));
    chk("h_data", 64'(h_data), 64'(v.eh));
    chk("h_last", 64'(h_last), 64'(v.xl));
    if (exp_sc != 16'hFFFF) exp_sc = exp_sc + 16'd1;
`ifdef LSTM_STEP_CNT_EN
    chk("step_cnt", 64'(step_cnt), 64'(exp_sc));
`endif
    tick();
    chk("h_valid_after_hs", 64'(h_valid), 64'd0);
    chk("x_ready_after_hs", 64'(x_ready), 64'd1);
    if (v.xl) begin
      exp_sc = 16'd0;
      chk("ht1_cleared", cell_ht1, 64'd0);
      chk("ct1_cleared", 64'(cell_ct1), 64'd0);
    end else begin
      chk("ht1_shift", cell_ht1, {v.e_ht1[55:0], v.eh});
    end
`ifdef LSTM_STEP_CNT_EN
    chk("step_cnt_post", 64'(step_cnt), 64'(exp_sc));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    tbl[0] = '{64'hFF00_0000_0000_0005, 1'b1, 8'h05, 64'h0,    8'h00};
    tbl[1] = '{64'h0000_0000_0000_0001, 1'b0, 8'h01, 64'h0,    8'h00};
    tbl[2] = '{64'h0000_0000_0000_0002, 1'b0, 8'h03, 64'h01,   8'h01};
    tbl[3] = '{64'h0000_0000_0000_0003, 1'b1, 8'h06, 64'h0103, 8'h02};
    tbl[4] = '{64'h1122_3344_5566_7710, 1'b0, 8'h10, 64'h0,    8'h00};
    tbl[5] = '{64'h0000_0000_0000_0020, 1'b1, 8'h30, 64'h10,   8'h01};

    // Reset held with x_valid asserted
    reset_n = 1'b0;
    x_valid = 1'b1;
    x_data  = 64'h1234_5678_9ABC_DEF0;
    x_last  = 1'b1;
    h_ready = 1'b0;
    repeat (3) tick();
    chk("rst_x_ready", 64'(x_ready), 64'd1);
    chk("rst_h_valid", 64'(h_valid), 64'd0);
    chk("rst_cell_xt", cell_xt, 64'd0);
    chk("rst_cell_ht1", cell_ht1, 64'd0);
    chk("rst_cell_ct1", 64'(cell_ct1), 64'd0);
    chk("rst_h_data", 64'(h_data), 64'd0);
    chk("rst_h_last", 64'(h_last), 64'd0);
`ifdef LSTM_STEP_CNT_EN
    chk("rst_step_cnt", 64'(step_cnt), 64'd0);
`endif
    x_valid = 1'b0;
    reset_n = 1'b1;
    tick();
    chk("post_rst_idle", 64'(x_ready), 64'd1);
    chk("post_rst_xt", cell_xt, 64'd0);

    for (int i = 0; i < 6; i++) begin
      run_step(tbl[i]);
    end

    // Output backpressure for 10 cycles, with a competing x_t offered
    x_data  = 64'h09;
    x_last  = 1'b1;
    x_valid = 1'b1;
    h_ready = 1'b0;
    tick();
    x_data  = 64'h44;
    n = 0;
    while (!h_valid && n < 40) begin
      tick();
      n++;
    end
    chk("bp_latency", 64'(n), 64'(CELL_LAT));
    for (int i = 0; i < 10; i++) begin
      chk("bp_h_valid", 64'(h_valid), 64'd1);
      chk("bp_h_data", 64'(h_data), 64'h09);
      chk("bp_x_ready", 64'(x_ready), 64'd0);
      tick();
    end
    chk("bp_xt_held", cell_xt, 64'h09);
    x_valid = 1'b0;
    h_ready = 1'b1;
    tick();
    chk("bp_release_x_ready", 64'(x_ready), 64'd1);
    chk("bp_release_h_valid", 64'(h_valid), 64'd0);
    chk("bp_ht1_cleared", cell_ht1, 64'd0);
    exp_sc = 16'd0;

    // Reset two edges into a step
    x_data  = 64'h11;
    x_last  = 1'b0;
    x_valid = 1'b1;
    tick();
    x_valid = 1'b0;
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("mrst_x_ready", 64'(x_ready), 64'd1);
    chk("mrst_h_valid", 64'(h_valid), 64'd0);
    chk("mrst_cell_xt", cell_xt, 64'd0);
    chk("mrst_cell_ht1", cell_ht1, 64'd0);
    chk("mrst_cell_ct1", 64'(cell_ct1), 64'd0);
    exp_sc = 16'd0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("mrst_no_phantom", 64'(h_valid), 64'd0);
    end
    run_step('{64'h07, 1'b1, 8'h07, 64'h0, 8'h00});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
